sm4_arbiter: RTL and testbench
==============================

# sm4_arbiter

Two-requester front end for one shared `sm4_top` core. It accepts encrypt/decrypt requests on two independent valid/ready ports and grants the core round-robin. It sequences the core's `en`/`done` protocol, captures the result, and returns it on the matching response port. It sits between the system-side clients and the single SM4 datapath instance.

## Interface
- `TIMEOUT_CYCLES`, 1024: WAIT-state watchdog limit in cycles; only used with `SM4_ARB_TIMEOUT_EN`.
- `clk  in  1`: single clock; all logic is on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `reqN_valid  in  1` (N=0,1): request present.
- `reqN_ready  out  1`: arbiter accepts the request this cycle.
- `reqN_mode  in  1`: 1 = encrypt, 0 = decrypt.
- `reqN_text  in  128`: plaintext or ciphertext.
- `reqN_key  in  128`: key.
- `respN_valid  out  1`: result available.
- `respN_ready  in  1`: client consumes the result.
- `respN_text  out  128`: result block.
- `respN_err  out  1`: result is a timeout, not a valid block.
- `core_en  out  1`: start pulse to `sm4_top`.
- `core_mode  out  1`: mode to the core.
- `core_intext  out  128`: input block to the core.
- `core_key  out  128`: key to the core.
- `core_outtext  in  128`: core result.
- `core_done  in  1`: core completion.

## Operation
- FSM states: IDLE, START, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - Grant = the single valid requester. If both are valid, grant the requester ≠ `last`.
  - `reqN_ready` = (state==IDLE) && (grant==N). It is combinational and is never high for both ports.
  - On valid&&ready: latch mode, text and key into core-side registers, record `owner`, go to START.
- **START**
  - `core_en`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - A `core_done` rising edge (`done_q` register, reset 0) latches `core_outtext` into the owner's response register and sets `err`=0. Go to RESP.
  - A level-high `core_done` carried over from a previous operation is ignored.
- **RESP**
  - `resp[owner]_valid`=1, holding the text and err stable until `resp[owner]_ready`.
  - On the handshake: `last`←`owner`, go to IDLE.
  - The other port's `resp_valid` stays 0.
- Core-side registers `core_mode`, `core_intext` and `core_key` hold steady from START through RESP. The core sees stable inputs for the whole operation.
- New requests are not accepted while not in IDLE. One operation is in flight at most.

## Timing
- Reset values:
  - all `reqN_ready`, `respN_valid`, `respN_err` and `core_en` = 0;
  - `respN_text`, `core_intext`, `core_key` = 0; `core_mode` = 0;
  - `last` = 1, so req0 wins the first tie.
- Latency:
  - Accept handshake at cycle 0; `core_en` high at cycle 1; WAIT from cycle 2.
  - A done rising edge sampled at cycle D gives `resp_valid` at cycle D+1.
  - An immediate `resp_ready` returns to IDLE the cycle after, so the next accept is possible at cycle D+2.
- A response waiting in RESP blocks all new grants. There is no bypass.
- Reset asserted in any state returns to IDLE and clears outputs. The in-flight request is lost; the client must reissue it.
- If `core_done` rises in the same cycle the FSM enters WAIT, it is honoured.

## Configuration
- `SM4_ARB_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no done edge, go to RESP with `resp_text`=0 and `resp_err`=1.
  - A done edge on the same cycle as expiry wins: the result is normal with err=0.
- Not defined: no counter, `respN_err` tied 0, and WAIT lasts until a done edge.

## Test plan
- Encrypt path: req0, mode=1, text=key=0123456789ABCDEFFEDCBA9876543210 -> resp0_text=681edf34d206965e86b3e94f536e4246, resp0_err=0, and `core_en` is exactly one cycle wide.
- Decrypt path: req1, mode=0, text=681edf34d206965e86b3e94f536e4246, same key -> resp1_text=0123456789ABCDEFFEDCBA9876543210, and resp0_valid stays 0 throughout.
- Fairness: req0 and req1 valid continuously from reset -> grants ordered 0,1,0,1, and each response lands only on its own port.
- Backpressure: hold resp0_ready=0 for 20 cycles -> resp0_valid/text stable, req1_ready stays 0, and no second `core_en` is issued.
- Timeout (macro on, TIMEOUT_CYCLES=16): a core model that never raises done -> resp_valid with err=1 and text=0, 16 cycles after WAIT entry. With the macro off, the FSM stays in WAIT.
- Reset mid-WAIT: drop rst_n for 2 cycles -> all outputs at reset values. A late `core_done` is ignored, and the next request completes correctly.

Source files
------------

// File: rtl/sm4_arbiter.sv
// rtl/sm4_arbiter.sv - round-robin two-port front end for a shared sm4_top core
// Optional WAIT watchdog enabled by defining SM4_ARB_TIMEOUT_EN.
module sm4_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_mode,
    input  logic [127:0] req0_text,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_mode,
    input  logic [127:0] req1_text,
    input  logic [127:0] req1_key,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic [127:0] resp0_text,
    output logic         resp0_err,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [127:0] resp1_text,
    output logic         resp1_err,
    output logic         core_en,
    output logic         core_mode,
    output logic [127:0] core_intext,
    output logic [127:0] core_key,
    input  logic [127:0] core_outtext,
    input  logic         core_done
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t state, state_nx;
    logic   last, owner, done_q;
    logic   grant, grant_vld;
    logic   done_rise, timeout, resp_hs;

    // Round-robin: on a tie, the port that was not served last wins.
    assign grant_vld = req0_valid | req1_valid;
    assign grant     = (req0_valid && req1_valid) ? ~last : req1_valid;
    assign done_rise = core_done && !done_q;
    assign resp_hs   = owner ? resp1_ready : resp0_ready;

    assign req0_ready  = (state == IDLE) && grant_vld && !grant;
    assign req1_ready  = (state == IDLE) && grant_vld && grant;
    assign resp0_valid = (state == RESP) && !owner;
    assign resp1_valid = (state == RESP) && owner;
    assign core_en     = (state == START);

`ifdef SM4_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err0_q, err1_q;

    // Counter is held at zero outside WAIT, so it starts from zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else if (state == WAIT && (done_rise || timeout)) begin
            if (owner) begin
                err1_q <= !done_rise;
            end else begin
                err0_q <= !done_rise;
            end
        end
    end

    assign resp0_err = err0_q;
    assign resp1_err = err1_q;
`else
    // Watchdog absent: WAIT only ends on a done edge.
    assign timeout   = (TIMEOUT_CYCLES < 0);
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (done_rise || timeout) state_nx = RESP;
            RESP:    if (resp_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            last        <= 1'b1;
            owner       <= 1'b0;
            core_mode   <= 1'b0;
            core_intext <= '0;
            core_key    <= '0;
            resp0_text  <= '0;
            resp1_text  <= '0;
        end else begin
            state  <= state_nx;
            done_q <= core_done;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner       <= grant;
                        core_mode   <= grant ? req1_mode : req0_mode;
                        core_intext <= grant ? req1_text : req0_text;
                        core_key    <= grant ? req1_key  : req0_key;
                    end
                end
                WAIT: begin
                    // A done edge coinciding with expiry still yields the real result.
                    if (done_rise || timeout) begin
                        if (owner) begin
                            resp1_text <= done_rise ? core_outtext : '0;
                        end else begin
                            resp0_text <= done_rise ? core_outtext : '0;
                        end
                    end
                end
                RESP: begin
                    if (resp_hs) last <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_arbiter.sv
// tb/tb_sm4_arbiter.sv - self-checking bench for sm4_arbiter with a behavioural core model
module tb_sm4_arbiter;

    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] KA = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req0_mode = 1'b0;
    logic [127:0] req0_text = '0, req0_key = '0;
    logic         req1_valid = 1'b0, req1_mode = 1'b0;
    logic [127:0] req1_text = '0, req1_key = '0;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic         resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [127:0] resp0_text, resp1_text;
    logic         core_en, core_mode;
    logic [127:0] core_intext, core_key;
    logic [127:0] core_outtext = '0;
    logic         core_done = 1'b0;

    always #5 clk = ~clk;

    sm4_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_text(req0_text), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_text(req1_text), .req1_key(req1_key),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_text(resp0_text),
        .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_text(resp1_text),
        .resp1_err(resp1_err),
        .core_en(core_en), .core_mode(core_mode), .core_intext(core_intext),
        .core_key(core_key), .core_outtext(core_outtext), .core_done(core_done)
    );

    typedef struct {
        int           port;
        logic [127:0] text;
        logic         err;
    } exp_t;

    typedef struct {
        int           port;
        logic         mode;
        logic [127:0] text;
        logic [127:0] key;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   core_lat = 3;
    bit   core_hang = 1'b0;
    int   en_len = 0;
    int   n_en = 0;

    // Known SM4 vector pair, otherwise an arbitrary stand-in transform.
    function automatic logic [127:0] core_fn(input logic m, input logic [127:0] t, input logic [127:0] k);
        if (m && t == PT && k == PT) return CT;
        if (!m && t == CT && k == PT) return PT;
        return t ^ {k[63:0], k[127:64]} ^ {128{m}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: done drops on en, rises core_lat cycles later and stays high.
    int           cm_cnt = 0;
    bit           cm_busy = 1'b0;
    logic [127:0] cm_res = '0;
    always @(negedge clk) begin
        if (core_en) begin
            core_done = 1'b0;
            cm_busy   = 1'b1;
            cm_cnt    = core_lat;
            cm_res    = core_fn(core_mode, core_intext, core_key);
        end else if (cm_busy && !core_hang) begin
            if (cm_cnt <= 1) begin
                core_done    = 1'b1;
                core_outtext = cm_res;
                cm_busy      = 1'b0;
            end else begin
                cm_cnt--;
            end
        end
    end

    task automatic resp_seen(input int p, input logic [127:0] t, input logic e);
        exp_t x;
        if (sb.size() == 0) begin
            check("resp_unexpected", 128'(p + 1), 128'd0);
        end else begin
            x = sb.pop_front();
            check("resp_port", 128'(p), 128'(x.port));
            check("resp_text", t, x.text);
            check("resp_err", {127'd0, e}, {127'd0, x.err});
        end
    endtask

    always @(negedge clk) begin
        if (core_en) begin
            if (en_len == 0) n_en++;
            en_len++;
        end else if (en_len != 0) begin
            check("core_en_width", 128'(en_len), 128'd1);
            en_len = 0;
        end
        if (req0_ready && req1_ready) check("ready_exclusive", 128'd1, 128'd0);
        if (resp0_valid && resp1_valid) check("resp_exclusive", 128'd1, 128'd0);
        if (resp0_valid && resp0_ready) resp_seen(0, resp0_text, resp0_err);
        if (resp1_valid && resp1_ready) resp_seen(1, resp1_text, resp1_err);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req0_ready", {127'd0, req0_ready}, 128'd0);
        check("rst_req1_ready", {127'd0, req1_ready}, 128'd0);
        check("rst_resp0_valid", {127'd0, resp0_valid}, 128'd0);
        check("rst_resp1_valid", {127'd0, resp1_valid}, 128'd0);
        check("rst_resp_err", {126'd0, resp1_err, resp0_err}, 128'd0);
        check("rst_resp0_text", resp0_text, 128'd0);
        check("rst_resp1_text", resp1_text, 128'd0);
        check("rst_core_en", {127'd0, core_en}, 128'd0);
        check("rst_core_mode", {127'd0, core_mode}, 128'd0);
        check("rst_core_intext", core_intext, 128'd0);
        check("rst_core_key", core_key, 128'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Returns one cycle after the accepting edge (the START cycle).
    task automatic send(input int p, input logic m, input logic [127:0] t, input logic [127:0] k);
        int n = 0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_mode = m; req0_text = t; req0_key = k;
        end else begin
            req1_valid = 1'b1; req1_mode = m; req1_text = t; req1_key = k;
        end
        #1;
        while (!(p == 0 ? req0_ready : req1_ready) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("accept_timeout", 128'd1, 128'd0);
        tick();
        if (p == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
    endtask

    vec_t vt[6];
    int   n;
    bit   seen;
    logic [127:0] hold;
    int   en0;

    initial begin
        vt[0] = '{0, 1'b1, PT, PT, CT, 3};
        vt[1] = '{1, 1'b0, CT, PT, PT, 1};
        vt[2] = '{0, 1'b0, 128'hdeadbeef_00000000_cafef00d_12345678, KA,
                  core_fn(1'b0, 128'hdeadbeef_00000000_cafef00d_12345678, KA), 5};
        vt[3] = '{1, 1'b1, 128'h0, KA, core_fn(1'b1, 128'h0, KA), 2};
        vt[4] = '{1, 1'b1, PT, PT, CT, 7};
        vt[5] = '{0, 1'b0, CT, PT, PT, 1};

        tick(2);
        check_reset_vals();
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 6; i++) begin
            core_lat = vt[i].lat;
            sb.push_back('{vt[i].port, vt[i].exp, 1'b0});
            send(vt[i].port, vt[i].mode, vt[i].text, vt[i].key);
            drain(100);
        end

        // Latency: done seen on WAIT entry, resp next cycle, next accept one later
        core_lat = 1;
        sb.push_back('{0, CT, 1'b0});
        send(0, 1'b1, PT, PT);
        check("lat_core_en_c1", {127'd0, core_en}, 128'd1);
        req1_valid = 1'b1; req1_mode = 1'b0; req1_text = CT; req1_key = PT;
        sb.push_back('{1, PT, 1'b0});
        tick();
        check("lat_core_en_c2", {127'd0, core_en}, 128'd0);
        check("lat_resp_c2", {127'd0, resp0_valid}, 128'd0);
        tick();
        check("lat_resp_c3", {127'd0, resp0_valid}, 128'd1);
        check("lat_req1_blocked", {127'd0, req1_ready}, 128'd0);
        tick();
        check("lat_accept_c4", {127'd0, req1_ready}, 128'd1);
        tick();
        req1_valid = 1'b0;
        drain(100);

        // Fairness from reset: both valid continuously
        do_reset();
        core_lat = 2;
        sb.push_back('{0, core_fn(1'b1, PT, KA), 1'b0});
        sb.push_back('{1, core_fn(1'b0, KA, PT), 1'b0});
        sb.push_back('{0, core_fn(1'b1, PT, KA), 1'b0});
        sb.push_back('{1, core_fn(1'b0, KA, PT), 1'b0});
        req0_valid = 1'b1; req0_mode = 1'b1; req0_text = PT; req0_key = KA;
        req1_valid = 1'b1; req1_mode = 1'b0; req1_text = KA; req1_key = PT;
        drain(200);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Backpressure on resp0 with req1 pending
        resp0_ready = 1'b0;
        core_lat = 3;
        sb.push_back('{0, core_fn(1'b1, KA, PT), 1'b0});
        send(0, 1'b1, KA, PT);
        req1_valid = 1'b1; req1_mode = 1'b1; req1_text = PT; req1_key = PT;
        sb.push_back('{1, CT, 1'b0});
        n = 0;
        while (!resp0_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_resp_arrives", {127'd0, resp0_valid}, 128'd1);
        hold = resp0_text;
        en0 = n_en;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid_held", {127'd0, resp0_valid}, 128'd1);
            check("bp_text_held", resp0_text, hold);
            check("bp_req1_blocked", {127'd0, req1_ready}, 128'd0);
        end
        check("bp_no_core_en", 128'(n_en), 128'(en0));
        resp0_ready = 1'b1;
        n = 0;
        while (!req1_ready && n < 10) begin
            tick();
            n++;
        end
        tick();
        req1_valid = 1'b0;
        drain(100);

        // Core that never finishes
        do_reset();
        core_hang = 1'b1;
`ifdef SM4_ARB_TIMEOUT_EN
        sb.push_back('{0, 128'd0, 1'b1});
`endif
        send(0, 1'b1, PT, PT);
        req1_valid = 1'b1; req1_mode = 1'b0; req1_text = CT; req1_key = PT;
        n = 1;
        while (!resp0_valid && n < 60) begin
            tick();
            n++;
        end
`ifdef SM4_ARB_TIMEOUT_EN
        check("timeout_latency", 128'(n), 128'd18);
        req1_valid = 1'b0;
        drain(10);
`else
        check("no_timeout_resp", {127'd0, resp0_valid}, 128'd0);
        check("no_timeout_req1", {127'd0, req1_ready}, 128'd0);
        req1_valid = 1'b0;
`endif
        core_hang = 1'b0;
        do_reset();
        sb.delete();

        // Reset during WAIT, late done must be ignored
        core_lat = 10;
        sb.push_back('{1, PT, 1'b0});
        send(1, 1'b0, CT, PT);
        tick(3);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        tick(2);
        sb.delete();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (resp0_valid || resp1_valid) seen = 1'b1;
        end
        check("late_done_ignored", {127'd0, seen}, 128'd0);
        core_lat = 2;
        sb.push_back('{1, PT, 1'b0});
        send(1, 1'b0, CT, PT);
        drain(100);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
